// File: rtl/calc_pkg.sv
// Shared encodings and default widths for the calculator sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_pkg;

    localparam int DW_DEF      = 6;
    localparam int RW_DEF      = 10;
    localparam int NUM_OPS_DEF = 6;
    localparam int MODE_W      = 2;
    localparam int NUM_MODES   = 4;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/calc_mask_pick.sv
// Finds the lowest set mask bit at or above index start; none=1 when no such bit exists.
// Latency: combinational.
// Backpressure: none.
module calc_mask_pick
    import calc_pkg::*;
(
    input  logic [NUM_MODES-1:0] mask,
    input  logic [MODE_W:0]      start,
    output logic [MODE_W-1:0]    idx,
    output logic                 none
);

    always_comb begin
        idx  = '0;
        none = 1'b1;
        // Scan downwards so the lowest qualifying bit is the one that sticks.
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                idx  = MODE_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Loads NUM_OPS operands, steps calc_mode through the selected modes and streams results; CALC_SEQ_BATCH_CNT_EN adds batch_cnt.
// Latency: res_valid rises CALC_LAT cycles after the last operand handshake, then per mode.
// Backpressure: in_ready only in LOAD; results held indefinitely until res_ready.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int RW       = RW_DEF,
    parameter int NUM_OPS  = NUM_OPS_DEF,
    parameter int CALC_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic [NUM_MODES-1:0]    mode_mask,
    output logic [NUM_OPS*DW-1:0]   calc_n,
    output logic [MODE_W-1:0]       calc_mode,
    input  logic [RW-1:0]           calc_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RW-1:0]           res_data,
    output logic [MODE_W-1:0]       res_mode,
    output logic                    res_last,
    output logic                    busy
`ifdef CALC_SEQ_BATCH_CNT_EN
    ,
    output logic [7:0]              batch_cnt
`endif
);

    localparam int          CNT_W     = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [3:0]  WAIT_LAST = 4'(CALC_LAT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           wait_q;
    logic [NUM_MODES-1:0] mask_q;

    logic                 in_hs, last_op, res_hs, wait_done;
    logic [MODE_W-1:0]    first_idx, nxt_idx;
    logic                 first_none, nxt_none;

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign in_hs     = in_valid && in_ready;
    assign last_op   = in_hs && (cnt_q == CNT_W'(NUM_OPS - 1));
    assign res_hs    = res_valid && res_ready;
    assign wait_done = (state_q == ST_WAIT) && (wait_q == WAIT_LAST);

    // First pick looks at the live mask; later steps use the latched one.
    calc_mask_pick u_pick_first (
        .mask  (mode_mask),
        .start ('0),
        .idx   (first_idx),
        .none  (first_none)
    );

    calc_mask_pick u_pick_next (
        .mask  (mask_q),
        .start ({1'b0, calc_mode} + 3'd1),
        .idx   (nxt_idx),
        .none  (nxt_none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (last_op && !first_none) state_d = ST_WAIT;
            ST_WAIT: if (wait_done)              state_d = ST_OUT;
            ST_OUT:  if (res_hs)                 state_d = res_last ? ST_LOAD : ST_WAIT;
            default:                             state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            wait_q    <= '0;
            mask_q    <= '0;
            calc_n    <= '0;
            calc_mode <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_mode  <= '0;
            res_last  <= 1'b0;
        end else begin
            if (in_hs) begin
                calc_n[cnt_q*DW +: DW] <= in_data;
                cnt_q <= last_op ? '0 : cnt_q + 1'b1;
            end
            if (last_op) begin
                mask_q <= mode_mask;
                if (!first_none) begin
                    calc_mode <= first_idx;
                    wait_q    <= '0;
                end
            end
            if (state_q == ST_WAIT) begin
                wait_q <= wait_q + 1'b1;
                if (wait_done) begin
                    res_data  <= calc_out;
                    res_mode  <= calc_mode;
                    res_last  <= nxt_none;
                    res_valid <= 1'b1;
                end
            end
            if (res_hs) begin
                res_valid <= 1'b0;
                if (res_last) begin
                    res_last <= 1'b0;
                end else begin
                    calc_mode <= nxt_idx;
                    wait_q    <= '0;
                end
            end
        end
    end

`ifdef CALC_SEQ_BATCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 batch_cnt <= '0;
        else if (res_hs && res_last) batch_cnt <= batch_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: two instances (CALC_LAT=1 and 3) share stimulus, each with a calculator stub.
// Expected result beats are queued at load time and popped by a monitor on each result handshake.
module tb_calc_seq_ctrl;

    typedef struct {
        logic [9:0] d;
        logic [1:0] m;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_data = '0;
    logic [3:0]  mode_mask = '0;
    logic        res_ready = 1'b0;

    logic        in_ready1, res_valid1, res_last1, busy1;
    logic [35:0] calc_n1;
    logic [1:0]  calc_mode1, res_mode1;
    logic [9:0]  calc_out1, res_data1;
    logic        in_ready3, res_valid3, res_last3, busy3;
    logic [35:0] calc_n3;
    logic [1:0]  calc_mode3, res_mode3;
    logic [9:0]  calc_out3, res_data3;
`ifdef CALC_SEQ_BATCH_CNT_EN
    logic [7:0]  batch_cnt1, batch_cnt3;
`endif

    int    checks = 0;
    int    errors = 0;
    beat_t exp1[$];
    beat_t exp3[$];
    beat_t mon_b1, mon_b3;
    logic [35:0] last_n;
    logic [5:0]  ops [6];

    always #5 clk = ~clk;

    function automatic logic [9:0] stub(input logic [35:0] n, input logic [1:0] m);
        logic [9:0] s;
        s = {m, 8'd0};
        for (int i = 0; i < 6; i++) s = s + 10'(n[i*6 +: 6]);
        return s;
    endfunction

    assign calc_out1 = stub(calc_n1, calc_mode1);
    assign calc_out3 = stub(calc_n3, calc_mode3);

    calc_seq_ctrl #(.CALC_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .mode_mask(mode_mask), .calc_n(calc_n1),
        .calc_mode(calc_mode1), .calc_out(calc_out1), .res_valid(res_valid1),
        .res_ready(res_ready), .res_data(res_data1), .res_mode(res_mode1),
        .res_last(res_last1), .busy(busy1)
`ifdef CALC_SEQ_BATCH_CNT_EN
        , .batch_cnt(batch_cnt1)
`endif
    );

    calc_seq_ctrl #(.CALC_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .mode_mask(mode_mask), .calc_n(calc_n3),
        .calc_mode(calc_mode3), .calc_out(calc_out3), .res_valid(res_valid3),
        .res_ready(res_ready), .res_data(res_data3), .res_mode(res_mode3),
        .res_last(res_last3), .busy(busy3)
`ifdef CALC_SEQ_BATCH_CNT_EN
        , .batch_cnt(batch_cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid1 && res_ready) begin
                chk("d1_beat_expected", exp1.size() != 0, 1'b1);
                if (exp1.size() != 0) begin
                    mon_b1 = exp1.pop_front();
                    chk("d1_res_data", res_data1, mon_b1.d);
                    chk("d1_res_mode", res_mode1, mon_b1.m);
                    chk("d1_res_last", res_last1, mon_b1.l);
                end
            end
            if (res_valid3 && res_ready) begin
                chk("d3_beat_expected", exp3.size() != 0, 1'b1);
                if (exp3.size() != 0) begin
                    mon_b3 = exp3.pop_front();
                    chk("d3_res_data", res_data3, mon_b3.d);
                    chk("d3_res_mode", res_mode3, mon_b3.m);
                    chk("d3_res_last", res_last3, mon_b3.l);
                end
            end
        end
    end

    task automatic chk_rst();
        chk("rst_in_ready1", in_ready1, 1'b1);   chk("rst_in_ready3", in_ready3, 1'b1);
        chk("rst_busy1", busy1, 1'b0);           chk("rst_busy3", busy3, 1'b0);
        chk("rst_res_valid1", res_valid1, 1'b0); chk("rst_res_valid3", res_valid3, 1'b0);
        chk("rst_calc_n1", calc_n1, '0);         chk("rst_calc_n3", calc_n3, '0);
        chk("rst_calc_mode1", calc_mode1, '0);   chk("rst_res_data1", res_data1, '0);
        chk("rst_res_mode1", res_mode1, '0);     chk("rst_res_last1", res_last1, 1'b0);
`ifdef CALC_SEQ_BATCH_CNT_EN
        chk("rst_batch_cnt1", batch_cnt1, '0);
`endif
    endtask

    // Caller sits just after a rising edge; returns 1ns after the last operand's edge.
    task automatic load_batch(input logic [3:0] mask, input int max_gap);
        logic [9:0] sum;
        logic       hi;
        beat_t      b;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk); #1;
            end
            in_valid  = 1'b1;
            in_data   = ops[i];
            mode_mask = (i == 5) ? mask : 4'($urandom);
            @(posedge clk); #1;
            in_valid  = 1'b0;
        end
        sum = '0;
        for (int i = 0; i < 6; i++) begin
            sum = sum + 10'(ops[i]);
            last_n[i*6 +: 6] = ops[i];
        end
        for (int m = 0; m < 4; m++) begin
            if (mask[m]) begin
                hi = 1'b1;
                for (int k = m + 1; k < 4; k++) if (mask[k]) hi = 1'b0;
                b.d = sum + 10'(m * 256);
                b.m = 2'(m);
                b.l = hi;
                exp1.push_back(b);
                exp3.push_back(b);
            end
        end
    endtask

    task automatic meas_lat();
        int l1 = -1;
        int l3 = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("load_calc_n1", calc_n1, last_n);
                chk("load_calc_n3", calc_n3, last_n);
                chk("wait_in_ready3", in_ready3, 1'b0);
                chk("wait_busy3", busy3, 1'b1);
            end
            if (l1 < 0 && res_valid1) l1 = c;
            if (l3 < 0 && res_valid3) l3 = c;
        end
        chk("latency_d1", 64'(l1), 64'd1);
        chk("latency_d3", 64'(l3), 64'd3);
    endtask

    task automatic drain();
        logic done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (exp1.size() == 0 && exp3.size() == 0 && !busy1 && !busy3) done = 1'b1;
        end
        chk("drain_done", done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp1.delete();
        exp3.delete();
        #1;
        chk_rst();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 6; i++) ops[i] = 6'($urandom);
    endtask

    initial begin
        #3;
        chk_rst();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic batch, modes 1 and 3
        res_ready = 1'b1;
        ops = '{6'd33, 6'd27, 6'd25, 6'd6, 6'd5, 6'd0};
        load_batch(4'b1010, 0);
        meas_lat();
        drain();

        // full mask with results held back for 10 cycles
        res_ready = 1'b0;
        load_batch(4'hF, 0);
        repeat (4) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_valid1", res_valid1, 1'b1); chk("hold_data1", res_data1, 10'd96);
            chk("hold_mode1", res_mode1, 2'd0);   chk("hold_calc_mode1", calc_mode1, 2'd0);
            chk("hold_valid3", res_valid3, 1'b1); chk("hold_data3", res_data3, 10'd96);
            chk("hold_calc_mode3", calc_mode3, 2'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        drain();

        // zero mask drops the batch
        rand_ops();
        load_batch(4'b0000, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("zero_in_ready1", in_ready1, 1'b1); chk("zero_busy1", busy1, 1'b0);
            chk("zero_valid1", res_valid1, 1'b0);   chk("zero_in_ready3", in_ready3, 1'b1);
            chk("zero_busy3", busy3, 1'b0);         chk("zero_valid3", res_valid3, 1'b0);
        end
        @(posedge clk); #1;
        rand_ops();
        load_batch(4'b0101, 0);
        drain();

        // gapped operand streams
        rand_ops();
        load_batch(4'b0110, 3);
        meas_lat();
        drain();
        rand_ops();
        load_batch(4'b1001, 3);
        meas_lat();
        drain();

        // reset part-way through loading
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 6'(i + 7);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        do_reset();

        // reset while a result is pending
        res_ready = 1'b0;
        rand_ops();
        load_batch(4'b1000, 0);
        repeat (5) @(negedge clk);
        chk("pend_valid1", res_valid1, 1'b1);
        #1;
        do_reset();
        res_ready = 1'b1;
        ops = '{6'd33, 6'd27, 6'd25, 6'd6, 6'd5, 6'd0};
        load_batch(4'b1010, 0);
        meas_lat();
        drain();

`ifdef CALC_SEQ_BATCH_CNT_EN
        do_reset();
        for (int b = 0; b < 257; b++) begin
            rand_ops();
            load_batch(4'b0001, 0);
            drain();
        end
        chk("batch_cnt1_wrap", batch_cnt1, 8'd1);
        chk("batch_cnt3_wrap", batch_cnt3, 8'd1);
        rand_ops();
        load_batch(4'b0000, 0);
        repeat (5) @(negedge clk);
        chk("batch_cnt1_drop", batch_cnt1, 8'd1);
        chk("batch_cnt3_drop", batch_cnt3, 8'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencer for the six-operand, 2-bit-mode combinational calculator datapath (six 6-bit operands N0..N5, MODE, 10-bit OUT_N).
- Collects six operands serially over a valid/ready stream and holds them stable on the calculator inputs.
- Steps MODE through a caller-selected subset of the four modes and captures each result.
- Returns the results as a valid/ready result stream, one beat per selected mode, lowest mode first.

Parameters:
- DW, 6, operand width.
- RW, 10, result width (width of OUT_N).
- NUM_OPS, 6, operands per batch.
- CALC_LAT, 1, cycles MODE is held stable before OUT_N is captured; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand ready.
- in_data  in  DW  operand value.
- mode_mask  in  4  bit m set means run mode m; sampled on the handshake of the last operand.
- calc_n  out  NUM_OPS*DW  operand bank to the calculator; N0 is bits [DW-1:0].
- calc_mode  out  2  MODE to the calculator.
- calc_out  in  RW  OUT_N from the calculator.
- res_valid  out  1  result valid.
- res_ready  in  1  result ready.
- res_data  out  RW  captured result.
- res_mode  out  2  mode that produced res_data.
- res_last  out  1  marks the final result of the batch.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=LOAD, operand counter=0, calc_n=0, calc_mode=0, res_valid=0, res_data=0, res_mode=0, res_last=0, busy=0, latched mask=0.
  - in_ready=(state==LOAD), so it reads 1 during reset; the driver must hold in_valid=0 while rst_n=0.
- States: LOAD, WAIT, OUT.
- LOAD:
  - in_ready=1.
  - On each in_valid&in_ready edge, in_data is written to slot[cnt] and cnt increments.
  - Slots not yet rewritten keep their previous batch values on calc_n.
- Handshake on the last operand (cnt==NUM_OPS-1):
  - cnt is cleared and mode_mask is latched in the same edge.
  - Latched mask==0: stay in LOAD. No result is produced; the batch is silently dropped.
  - Otherwise: calc_mode = index of the lowest set bit, wait counter=0, go to WAIT.
- WAIT:
  - in_ready=0. calc_n and calc_mode are held stable.
  - The wait counter increments each cycle.
  - When the counter reaches CALC_LAT-1: res_data<=calc_out, res_mode<=calc_mode, res_last<=(no higher set bit in the mask), res_valid<=1, go to OUT.
  - Latency: last-operand handshake at edge T gives res_valid high after edge T+CALC_LAT.
- OUT:
  - res_valid and res_data are held until res_ready.
  - On handshake with more bits set: calc_mode = next higher set bit, clear the wait counter, go to WAIT. There is always at least one WAIT cycle between results.
  - On handshake with res_last=1: res_valid<=0, res_last<=0, go to LOAD. in_ready is 1 on the following cycle.
- Arithmetic: calc_out is captured unmodified. There is no width change; RW is owned by the calculator.
- Backpressure: res_ready may be held low indefinitely. Nothing is dropped and calc_mode does not change.
- Reset in mid-batch: all partially loaded operands and pending results are discarded. res_valid falls asynchronously.

Optional Feature:
- Macro: CALC_SEQ_BATCH_CNT_EN.
- Defined:
  - Adds output batch_cnt [7:0], reset 0.
  - Increments on each res_last handshake and wraps 255->0.
  - A dropped batch (mask==0) does not count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package calc_pkg holds:
  - state encoding constants (LOAD=0, WAIT=1, OUT=2);
  - MODE_W=2 and NUM_MODES=4;
  - the default operand and result widths.
- One natural sub-module, calc_mask_pick: combinational "next set bit above index i" over a 4-bit mask, with a none-found flag. It is used both for the first pick and for each subsequent step.

Test Plan:
- The bench uses a calculator stub: calc_out = sum(N0..N5) + 256*mode.
- Basic batch: operands 33,27,25,6,5,0, mask=4'b1010, res_ready=1, CALC_LAT=1 -> beats (mode1, 352, last=0) then (mode3, 864, last=1); first res_valid exactly 1 cycle after the 6th handshake.
- Full mask with res_ready low for 10 cycles: same operands, mask=4'hF -> res_data=96 held stable with mode0 throughout; after release, 96, 352, 608, 864 in order, last only on 864.
- Zero mask: load 6 operands with mask=0 -> res_valid never asserts; in_ready stays 1; busy stays 0; the next batch loads normally.
- In_valid gaps: randomise gaps between operands, CALC_LAT=3 -> calc_n matches operands in slot order; result appears 3 cycles after the last handshake.
- Reset mid-batch: assert rst_n=0 after 3 operands, then again while in OUT -> outputs return to reset values immediately; a fresh 6-operand batch yields correct results.
- With CALC_SEQ_BATCH_CNT_EN: run 257 single-mode batches -> batch_cnt reads 1; a mask=0 batch leaves it unchanged.
